// File: rtl/mul_sgn_iter.sv
// rtl/mul_sgn_iter.sv - iterative radix-2^STEP signed/unsigned multiplier with valid/ready handshakes.
// Optional accumulator output enabled by defining MULSGN_ITER_ACC_EN.
module mul_sgn_iter #(
  parameter int WIDTH_X = 8,
  parameter int WIDTH_Y = 8,
  parameter int STEP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_X-1:0]         X,
  input  logic [WIDTH_Y-1:0]         Y,
  input  logic                       sgn_x,
  input  logic                       sgn_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_X+WIDTH_Y-1:0] P
`ifdef MULSGN_ITER_ACC_EN
  ,
  input  logic                       acc_en,
  input  logic                       acc_clr,
  output logic [WIDTH_X+WIDTH_Y+1:0] ACC
`endif
);

  localparam int NITER = (WIDTH_X + STEP - 1) / STEP;
  localparam int XP    = NITER * STEP;
  localparam int PW    = WIDTH_X + WIDTH_Y;
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XP-1:0]   x_q, x_d;
  logic [PW-1:0]   y_q, y_d;
  logic            sgn_x_q, sgn_x_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   sum_q, sum_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [XP-1:0]   x_ext;
  logic [PW-1:0]   y_ext;
  logic [STEP-1:0] dig_u;
  logic [PW-1:0]   dig_ext;
  logic [PW-1:0]   pp;
  logic            last;

`ifdef MULSGN_ITER_ACC_EN
  logic [PW+1:0]   acc_q, acc_d;
  logic            acc_en_q, acc_en_d;
`endif

  always_comb begin
    x_ext = {XP{sgn_x & X[WIDTH_X-1]}};
    x_ext[WIDTH_X-1:0] = X;
    y_ext = {PW{sgn_y & Y[WIDTH_Y-1]}};
    y_ext[WIDTH_Y-1:0] = Y;

    // The final digit of a signed X is itself signed, giving the MSB its negative weight.
    last    = (cnt_q == CW'(NITER - 1));
    dig_u   = x_q[STEP-1:0];
    dig_ext = {PW{last & sgn_x_q & dig_u[STEP-1]}};
    dig_ext[STEP-1:0] = dig_u;
    pp = dig_ext * y_q;

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sgn_x_d     = sgn_x_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef MULSGN_ITER_ACC_EN
    acc_d    = acc_q;
    acc_en_d = acc_en_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x_ext;
          y_d        = y_ext;
          sgn_x_d    = sgn_x;
          cnt_d      = '0;
          sum_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
`ifdef MULSGN_ITER_ACC_EN
          acc_en_d = acc_en;
          if (acc_clr) acc_d = '0;
`endif
        end
      end
      BUSY: begin
        sum_d = sum_q + pp;
        x_d   = x_q >> STEP;
        y_d   = y_q << STEP;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
`ifdef MULSGN_ITER_ACC_EN
          if (acc_en_q) acc_d = acc_q + {{2{sum_q[PW-1]}}, sum_q};
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sgn_x_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MULSGN_ITER_ACC_EN
      acc_q    <= '0;
      acc_en_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sgn_x_q     <= sgn_x_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MULSGN_ITER_ACC_EN
      acc_q    <= acc_d;
      acc_en_q <= acc_en_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = sum_q;
`ifdef MULSGN_ITER_ACC_EN
  assign ACC       = acc_q;
`endif

endmodule

// File: tb/tb_mul_sgn_iter.sv
// tb/tb_mul_sgn_iter.sv - directed table-driven bench for mul_sgn_iter (8x8/2, 5x8/2, 8x8/8).
// Accumulator checks run when MULSGN_ITER_ACC_EN is defined.
module tb_mul_sgn_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0]  X = '0, Y = '0;
  logic        sgn_x = 1'b0, sgn_y = 1'b0;
  logic [15:0] P;

  logic        o_in_valid = 1'b0, o_in_ready, o_out_valid, o_out_ready = 1'b0;
  logic [4:0]  o_X = '0;
  logic [7:0]  o_Y = '0;
  logic        o_sx = 1'b0, o_sy = 1'b0;
  logic [12:0] o_P;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [7:0]  s_X = '0, s_Y = '0;
  logic        s_sx = 1'b0, s_sy = 1'b0;
  logic [15:0] s_P;

`ifdef MULSGN_ITER_ACC_EN
  logic        acc_en = 1'b0, acc_clr = 1'b0;
  logic [17:0] acc;
  logic [14:0] o_acc;
  logic [17:0] s_acc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_sgn_iter #(.WIDTH_X(8), .WIDTH_Y(8), .STEP(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .sgn_x(sgn_x), .sgn_y(sgn_y),
    .out_valid(out_valid), .out_ready(out_ready), .P(P)
`ifdef MULSGN_ITER_ACC_EN
    , .acc_en(acc_en), .acc_clr(acc_clr), .ACC(acc)
`endif
  );

  mul_sgn_iter #(.WIDTH_X(5), .WIDTH_Y(8), .STEP(2)) u_odd (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .X(o_X), .Y(o_Y), .sgn_x(o_sx), .sgn_y(o_sy),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .P(o_P)
`ifdef MULSGN_ITER_ACC_EN
    , .acc_en(1'b0), .acc_clr(1'b0), .ACC(o_acc)
`endif
  );

  mul_sgn_iter #(.WIDTH_X(8), .WIDTH_Y(8), .STEP(8)) u_one (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .X(s_X), .Y(s_Y), .sgn_x(s_sx), .sgn_y(s_sy),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .P(s_P)
`ifdef MULSGN_ITER_ACC_EN
    , .acc_en(1'b0), .acc_clr(1'b0), .ACC(s_acc)
`endif
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        sx;
    logic        sy;
    logic [15:0] p;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_out(input string name, input int exp_lat, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_vec(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic sx, input logic sy, input logic [15:0] exp);
    int lat;
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    X = x; Y = y; sgn_x = sx; sgn_y = sy;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    X = 8'hA5; Y = 8'h5A; sgn_x = ~sx; sgn_y = ~sy;
    wait_out(name, 4, lat);
    chk(name, P, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_odd(input string name, input logic [4:0] x, input logic [7:0] y,
                         input logic sx, input logic sy, input logic [12:0] exp);
    int lat = 0;
    o_X = x; o_Y = y; o_sx = sx; o_sy = sy;
    o_in_valid = 1'b1;
    step();
    o_in_valid = 1'b0;
    while (!o_out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk(name, o_P, exp);
    o_out_ready = 1'b1;
    step();
    o_out_ready = 1'b0;
    step();
  endtask

  task automatic run_one(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic sx, input logic sy, input logic [15:0] exp);
    int lat = 0;
    s_X = x; s_Y = y; s_sx = sx; s_sy = sy;
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    while (!s_out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, 1);
    chk(name, s_P, exp);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    step();
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    logic stray;

    vt[0]  = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
    vt[1]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
    vt[2]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    vt[3]  = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001};
    vt[4]  = '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h8080};
    vt[5]  = '{8'h7F, 8'h80, 1'b0, 1'b1, 16'hC080};
    vt[6]  = '{8'h00, 8'hAB, 1'b1, 1'b1, 16'h0000};
    vt[7]  = '{8'h12, 8'h34, 1'b0, 1'b0, 16'h03A8};
    vt[8]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 16'h3F80};
    vt[9]  = '{8'hFE, 8'h03, 1'b1, 1'b1, 16'hFFFA};
    vt[10] = '{8'h55, 8'hAA, 1'b0, 1'b1, 16'hE372};
    vt[11] = '{8'hFF, 8'h80, 1'b0, 1'b1, 16'h8080};

    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_P", P, 0);

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].sx, vt[i].sy, vt[i].p);

    // Backpressure: hold the product for five cycles, then release with a new request waiting.
    X = 8'h0C; Y = 8'h0B; sgn_x = 1'b0; sgn_y = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("bp", 4, lat);
    chk("bp_P", P, 16'h0084);
    held = P;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      chk($sformatf("bp_hold_P%0d", c), P, held);
      chk($sformatf("bp_hold_in_ready%0d", c), in_ready, 0);
    end
    X = 8'h02; Y = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("bp_accept_in_ready", in_ready, 0);
    wait_out("bp2", 4, lat);
    chk("bp2_P", P, 16'h0006);
    step();
    out_ready = 1'b0;

    // Reset part-way through an iteration discards the pending product.
    X = 8'h40; Y = 8'h40; sgn_x = 1'b1; sgn_y = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_P", P, 0);
    stray = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      stray |= out_valid;
    end
    chk("midrst_no_stray_valid", stray, 0);
    run_vec("after_rst", 8'h03, 8'h05, 1'b1, 1'b1, 16'h000F);

    run_odd("odd_neg16x7", 5'h10, 8'h07, 1'b1, 1'b1, 13'h1F90);
    run_odd("odd_31xm1", 5'h1F, 8'hFF, 1'b0, 1'b1, 13'h1FE1);
    run_odd("odd_m1xm1", 5'h1F, 8'hFF, 1'b1, 1'b1, 13'h0001);

    run_one("one_m128x3", 8'h80, 8'h03, 1'b1, 1'b0, 16'hFE80);
    run_one("one_255x255", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);

`ifdef MULSGN_ITER_ACC_EN
    acc_en = 1'b1;
    acc_clr = 1'b1;
    run_vec("acc_3x4", 8'h03, 8'h04, 1'b1, 1'b1, 16'h000C);
    chk("acc_12", acc, 18'd12);
    acc_clr = 1'b0;
    run_vec("acc_m2x5", 8'hFE, 8'h05, 1'b1, 1'b1, 16'hFFF6);
    chk("acc_2", acc, 18'd2);
    run_vec("acc_7x7", 8'h07, 8'h07, 1'b1, 1'b1, 16'h0031);
    chk("acc_51", acc, 18'd51);
    acc_clr = 1'b1;
    run_vec("acc_1x1", 8'h01, 8'h01, 1'b1, 1'b1, 16'h0001);
    chk("acc_1", acc, 18'd1);
    acc_clr = 1'b0;
    acc_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
